// File: rtl/pixel_stream_coord_gen_pkg.sv
// rtl/pixel_stream_coord_gen_pkg.sv - shared constants and state encoding for pixel_stream_coord_gen
package pixel_stream_coord_gen_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int COORD_W_DEF  = 10;
    localparam int STAT_W       = 16;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - parameterised-width saturating counter with increment enable
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pixel_stream_coord_gen.sv
// rtl/pixel_stream_coord_gen.sv - camera pixel stream to registered (x,y,value) frame-buffer writes
// Statistics counters are built only when PIXEL_STREAM_STATS_EN is defined.
module pixel_stream_coord_gen
    import pixel_stream_coord_gen_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int COORD_W  = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         pix_val,
    input  logic               pix_valid,
    input  logic               pix_sof,
    input  logic               pix_eol,
    input  logic               err_clr,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [7:0]         out_val,
    output logic               out_is_val,
    output logic               frame_done,
    output logic               err_sof_early,
    output logic               err_line_long,
    output logic               err_line_short,
    output logic [STAT_W-1:0]  frame_cnt,
    output logic [STAT_W-1:0]  drop_cnt
);

    // One spare bit so x can hold H_ACTIVE (saturation value) even when H_ACTIVE == 2^COORD_W.
    localparam int CW = COORD_W + 1;
    localparam logic [CW-1:0] H_LIM  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_LIM  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_LAST = CW'(V_ACTIVE - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d, cx, cy;
    logic          take, emit, drop, fd, set_sof, set_long, set_short;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        cx        = x_q;
        cy        = y_q;
        emit      = 1'b0;
        drop      = 1'b0;
        fd        = 1'b0;
        set_sof   = 1'b0;
        set_long  = 1'b0;
        set_short = 1'b0;
        take      = pix_valid && (pix_sof || (state_q == ACTIVE));
        if (take) begin
            if (pix_sof) begin
                cx      = '0;
                cy      = '0;
                state_d = ACTIVE;
                set_sof = (state_q == ACTIVE);
            end
            emit     = (cx < H_LIM) && (cy < V_LIM);
            drop     = !emit;
            set_long = drop;
            if (pix_eol) begin
                set_short = (cx < H_LAST);
                x_d       = '0;
                if (cy == V_LAST) begin
                    y_d     = '0;
                    state_d = WAIT_SOF;
                    fd      = 1'b1;
                end else begin
                    y_d = cy + 1'b1;
                end
            end else begin
                x_d = (cx >= H_LIM) ? H_LIM : cx + 1'b1;
                y_d = cy;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= WAIT_SOF;
            x_q            <= '0;
            y_q            <= '0;
            out_x          <= '0;
            out_y          <= '0;
            out_val        <= '0;
            out_is_val     <= 1'b0;
            frame_done     <= 1'b0;
            err_sof_early  <= 1'b0;
            err_line_long  <= 1'b0;
            err_line_short <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            out_is_val <= emit;
            frame_done <= fd;
            if (emit) begin
                out_x   <= cx[COORD_W-1:0];
                out_y   <= cy[COORD_W-1:0];
                out_val <= pix_val;
            end
            // A same-cycle set wins over err_clr.
            err_sof_early  <= (err_sof_early  && !err_clr) || set_sof;
            err_line_long  <= (err_line_long  && !err_clr) || set_long;
            err_line_short <= (err_line_short && !err_clr) || set_short;
        end
    end

`ifdef PIXEL_STREAM_STATS_EN
    sat_counter #(.W(STAT_W)) u_frame_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (fd),
        .count (frame_cnt)
    );

    sat_counter #(.W(STAT_W)) u_drop_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (drop),
        .count (drop_cnt)
    );
`else
    assign frame_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_pixel_stream_coord_gen.sv
// tb/tb_pixel_stream_coord_gen.sv - directed self-checking bench for pixel_stream_coord_gen (H=4, V=3)
module tb_pixel_stream_coord_gen;

`ifdef PIXEL_STREAM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  pix_val = '0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic        pix_eol = 1'b0;
    logic        err_clr = 1'b0;
    logic [9:0]  out_x, out_y;
    logic [7:0]  out_val;
    logic        out_is_val, frame_done;
    logic        err_sof_early, err_line_long, err_line_short;
    logic [15:0] frame_cnt, drop_cnt;

    int checks = 0;
    int fails  = 0;

    pixel_stream_coord_gen #(.H_ACTIVE(4), .V_ACTIVE(3), .COORD_W(10)) dut (
        .clk            (clk),
        .reset          (reset),
        .pix_val        (pix_val),
        .pix_valid      (pix_valid),
        .pix_sof        (pix_sof),
        .pix_eol        (pix_eol),
        .err_clr        (err_clr),
        .out_x          (out_x),
        .out_y          (out_y),
        .out_val        (out_val),
        .out_is_val     (out_is_val),
        .frame_done     (frame_done),
        .err_sof_early  (err_sof_early),
        .err_line_long  (err_line_long),
        .err_line_short (err_line_short),
        .frame_cnt      (frame_cnt),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] v, input logic valid, input logic sof,
                        input logic eol, input logic clr);
        @(negedge clk);
        pix_val   = v;
        pix_valid = valid;
        pix_sof   = sof;
        pix_eol   = eol;
        err_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_pix(input string tag, input int ex, input int ey, input logic [7:0] ev,
                           input logic efd);
        chk({tag, ".is_val"}, 32'(out_is_val), 32'd1);
        chk({tag, ".x"}, 32'(out_x), 32'(ex));
        chk({tag, ".y"}, 32'(out_y), 32'(ey));
        chk({tag, ".val"}, 32'(out_val), 32'(ev));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(efd));
    endtask

    task automatic exp_none(input string tag);
        chk({tag, ".is_val"}, 32'(out_is_val), 32'd0);
        chk({tag, ".frame_done"}, 32'(frame_done), 32'd0);
    endtask

    task automatic exp_err(input string tag, input logic es, input logic el, input logic esh);
        chk({tag, ".err_sof_early"}, 32'(err_sof_early), 32'(es));
        chk({tag, ".err_line_long"}, 32'(err_line_long), 32'(el));
        chk({tag, ".err_line_short"}, 32'(err_line_short), 32'(esh));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst.is_val", 32'(out_is_val), 32'd0);
        chk("rst.x", 32'(out_x), 32'd0);
        chk("rst.y", 32'(out_y), 32'd0);
        chk("rst.frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst.drop_cnt", 32'(drop_cnt), 32'd0);
        exp_err("rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Pre-SOF garbage, EOL markers included, must be ignored
        for (int i = 0; i < 10; i++) begin
            send(8'(8'hA0 + i), 1'b1, 1'b0, (i % 4) == 3, 1'b0);
            exp_none("garbage");
        end
        chk("garbage.drop_cnt", 32'(drop_cnt), 32'd0);
        exp_err("garbage", 1'b0, 1'b0, 1'b0);

        // Full 4x3 frame
        for (int i = 0; i < 12; i++) begin
            send(8'(8'h10 + i), 1'b1, i == 0, (i % 4) == 3, 1'b0);
            exp_pix("frame1", i % 4, i / 4, 8'(8'h10 + i), i == 11);
        end
        send(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_none("frame1.after");
        exp_err("frame1", 1'b0, 1'b0, 1'b0);
        chk("frame1.frame_cnt", 32'(frame_cnt), STATS ? 32'd1 : 32'd0);
        chk("frame1.drop_cnt", 32'(drop_cnt), 32'd0);

        // Gapped line: invalid cycles carry markers that must be ignored
        send(8'h40, 1'b1, 1'b1, 1'b0, 1'b0); exp_pix("gap0", 0, 0, 8'h40, 1'b0);
        send(8'h99, 1'b0, 1'b1, 1'b1, 1'b0); exp_none("gap_i0");
        send(8'h41, 1'b1, 1'b0, 1'b0, 1'b0); exp_pix("gap1", 1, 0, 8'h41, 1'b0);
        send(8'h98, 1'b0, 1'b0, 1'b1, 1'b0); exp_none("gap_i1");
        send(8'h42, 1'b1, 1'b0, 1'b0, 1'b0); exp_pix("gap2", 2, 0, 8'h42, 1'b0);
        send(8'h97, 1'b0, 1'b1, 1'b0, 1'b0); exp_none("gap_i2");
        send(8'h43, 1'b1, 1'b0, 1'b1, 1'b0); exp_pix("gap3", 3, 0, 8'h43, 1'b0);

        // Long line at y=1: pixels 4 and 5 dropped
        send(8'h50, 1'b1, 1'b0, 1'b0, 1'b0); exp_pix("long0", 0, 1, 8'h50, 1'b0);
        send(8'h51, 1'b1, 1'b0, 1'b0, 1'b0); exp_pix("long1", 1, 1, 8'h51, 1'b0);
        send(8'h52, 1'b1, 1'b0, 1'b0, 1'b0); exp_pix("long2", 2, 1, 8'h52, 1'b0);
        send(8'h53, 1'b1, 1'b0, 1'b0, 1'b0); exp_pix("long3", 3, 1, 8'h53, 1'b0);
        send(8'h54, 1'b1, 1'b0, 1'b0, 1'b0); exp_none("long4");
        chk("long4.err_line_long", 32'(err_line_long), 32'd1);
        send(8'h55, 1'b1, 1'b0, 1'b1, 1'b0); exp_none("long5");
        exp_err("long", 1'b0, 1'b1, 1'b0);
        chk("long.drop_cnt", 32'(drop_cnt), STATS ? 32'd2 : 32'd0);

        // Next line restarts at x=0, then early SOF at (2,2)
        send(8'h60, 1'b1, 1'b0, 1'b0, 1'b0); exp_pix("l2_0", 0, 2, 8'h60, 1'b0);
        send(8'h61, 1'b1, 1'b0, 1'b0, 1'b0); exp_pix("l2_1", 1, 2, 8'h61, 1'b0);
        send(8'h62, 1'b1, 1'b1, 1'b0, 1'b0); exp_pix("early_sof", 0, 0, 8'h62, 1'b0);
        exp_err("early_sof", 1'b1, 1'b1, 1'b0);

        // err_clr clears flags; a same-cycle set keeps its flag
        send(8'h00, 1'b0, 1'b0, 1'b0, 1'b1); exp_none("clr_idle");
        exp_err("clr_idle", 1'b0, 1'b0, 1'b0);
        send(8'h63, 1'b1, 1'b0, 1'b1, 1'b1); exp_pix("short", 1, 0, 8'h63, 1'b0);
        exp_err("short_clr", 1'b0, 1'b0, 1'b1);

        // Complete the restarted frame
        for (int i = 0; i < 8; i++) begin
            send(8'(8'h70 + i), 1'b1, 1'b0, (i % 4) == 3, 1'b0);
            exp_pix("frame2", i % 4, 1 + i / 4, 8'(8'h70 + i), i == 7);
        end
        chk("frame2.frame_cnt", 32'(frame_cnt), STATS ? 32'd2 : 32'd0);
        chk("frame2.drop_cnt", 32'(drop_cnt), STATS ? 32'd2 : 32'd0);
        send(8'h00, 1'b0, 1'b0, 1'b0, 1'b1); exp_none("clr2");
        exp_err("clr2", 1'b0, 1'b0, 1'b0);

        // SOF and EOL on the same pixel
        send(8'h80, 1'b1, 1'b1, 1'b1, 1'b0); exp_pix("sofeol", 0, 0, 8'h80, 1'b0);
        exp_err("sofeol", 1'b0, 1'b0, 1'b1);
        send(8'h81, 1'b1, 1'b0, 1'b0, 1'b0); exp_pix("sofeol_n0", 0, 1, 8'h81, 1'b0);
        send(8'h82, 1'b1, 1'b0, 1'b0, 1'b0); exp_pix("sofeol_n1", 1, 1, 8'h82, 1'b0);

        // Asynchronous reset mid-line
        #2;
        reset = 1'b0;
        #1;
        chk("arst.is_val", 32'(out_is_val), 32'd0);
        chk("arst.x", 32'(out_x), 32'd0);
        chk("arst.y", 32'(out_y), 32'd0);
        chk("arst.val", 32'(out_val), 32'd0);
        chk("arst.frame_cnt", 32'(frame_cnt), 32'd0);
        chk("arst.drop_cnt", 32'(drop_cnt), 32'd0);
        exp_err("arst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        pix_valid = 1'b0;
        reset = 1'b1;
        send(8'h90, 1'b1, 1'b0, 1'b0, 1'b0); exp_none("post_rst_nosof");
        send(8'h91, 1'b1, 1'b1, 1'b0, 1'b0); exp_pix("post_rst_sof", 0, 0, 8'h91, 1'b0);
        send(8'h92, 1'b1, 1'b0, 1'b0, 1'b0); exp_pix("post_rst_px1", 1, 0, 8'h92, 1'b0);
        chk("post_rst.drop_cnt", 32'(drop_cnt), 32'd0);
        chk("post_rst.frame_cnt", 32'(frame_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
